pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
// - Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready flow control.
// - Carries CTRL_W control bits (zeroed on bubble/flush) and DATA_W payload bits.
// - Adds stall, flush and an optional 2-entry skid buffer, so every pipeline boundary uses one block.
// PARAMETERS
// - DATA_W  32  payload width: ALU result, addresses, store data, register index
// - CTRL_W  6   control width: RegWrite, MemWrite, ...; forced to 0 whenever no valid beat is held
// - SKID    1   1 = 2-entry skid buffer, in_ready from state only; 0 = single entry, ready passes through
// PORTS
// - clk        in   1       clock; all state updates on rising edge
// - reset      in   1       synchronous, active-high reset
// - flush      in   1       kill all held beats (branch taken / interrupt)
// - in_valid   in   1       upstream beat valid
// - in_ready   out  1       stage can accept a beat this cycle
// - in_ctrl    in   CTRL_W  upstream control bits
// - in_data    in   DATA_W  upstream payload
// - out_valid  out  1       beat presented downstream
// - out_ready  in   1       downstream accepts; 0 = stall
// - out_ctrl   out  CTRL_W  held control bits; all 0 when out_valid=0
// - out_data   out  DATA_W  held payload; value when out_valid=0 is don't-care (holds last)
// - occupancy  out  2       number of held beats: 0, 1 or 2
// BEHAVIOUR
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - Reset (sync): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid regs=0.
// - in_ready is 0 while reset or flush is high.
// - Latency: 1 cycle from accepted beat to out_valid when EMPTY. Throughput: 1 beat/cycle.
// - SKID=1 states (main slot M, skid slot S):
//   - EMPTY: in_ready=1. Accept -> M, go to ONE.
//   - ONE:   in_ready=1.
//     - Accept & out_ready   -> M<=in, stay ONE.
//     - Accept & !out_ready  -> S<=in, go to TWO.
//     - !accept & out_ready  -> go to EMPTY.
//   - TWO:   in_ready=0. out_ready -> M<=S, go to ONE; else hold.
//   - in_ready is a function of state only (no combinational path out_ready->in_ready).
// - SKID=0: single slot. in_ready = !out_valid | out_ready.
//   - Accept loads M; out transfer without accept clears valid.
// - Order preserved: beats leave in acceptance order; no beat is duplicated or dropped except by flush.
// - Flush: all held beats discarded next edge; state EMPTY, out_valid=0, out_ctrl=0.
//   - A beat offered in the flush cycle is not accepted (in_ready=0).
// - Priority: reset > flush > normal flow.
// - Reset/flush mid-stall (state TWO) empties both slots in one cycle.
// - out_ctrl = valid ? M.ctrl : 0, so a bubble never writes a register or memory.
// - occupancy is registered and equals the number of held beats after each edge.
// STRUCTURE
// - pipe_pkg: state enum {ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2}.
// - pipe_pkg: localparam helper CTRL_NOP (all-zero ctrl).
// - One sub-module, pipe_slot: ctrl+data register with load enable and sync clear.
//   - Instantiated as M always; as S only when SKID=1 (generate).
// - FSM and ready logic live in pipe_stage_buf.
// TESTING
// - Reset: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; in_ready=1 after release.
// - Stream: out_ready=1, beats data=1,2,3 on consecutive cycles -> out_data 1,2,3 on the next 3 cycles, occupancy stays 1.
// - Stall (SKID=1): send 0xA then 0xB with out_ready=0.
//   -> occupancy=2, in_ready=0, out_data=0xA held.
//   - Raise out_ready -> 0xA then 0xB appear, in order.
// - Flush in TWO: state TWO, flush=1 with in_valid=1, in_data=0xC.
//   -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears.
// - Bubble ctrl: in_ctrl=6'h3F beat drained, then no input -> out_ctrl=0 while out_valid=0.
// - SKID=0: out_ready toggling 1,0,1 with continuous in_valid.
//   -> in_ready follows out_ready while full; no loss, no duplicate.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline buffer: FSM state encoding and the bubble control word.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Control word for a bubble; sliced to CTRL_W at the point of use.
    localparam logic [63:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One beat of pipeline storage: control and payload registers with load enable and synchronous clear.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (ld_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and an optional 2-entry skid buffer.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e state_q, state_d;

    logic              clr;
    logic              acc;
    logic              m_ld;
    logic              m_from_s;
    logic              s_ld;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
    logic [DATA_W-1:0] m_data, s_data, m_data_d;

    assign clr       = reset | flush;
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;

    // With the skid slot, in_ready depends on state only, breaking the out_ready -> in_ready path.
    generate
        if (SKID != 0) begin : g_rdy_skid
            assign in_ready = ~clr & (state_q != ST_TWO);
        end else begin : g_rdy_pass
            assign in_ready = ~clr & (~out_valid | out_ready);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        m_ld     = 1'b0;
        m_from_s = 1'b0;
        s_ld     = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    m_ld    = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && out_ready) begin
                    m_ld = 1'b1;
                end else if (acc) begin
                    if (SKID != 0) begin
                        s_ld    = 1'b1;
                        state_d = ST_TWO;
                    end
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    m_ld     = 1'b1;
                    m_from_s = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign m_ctrl_d = m_from_s ? s_ctrl : in_ctrl;
    assign m_data_d = m_from_s ? s_data : in_data;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .clr_i  (clr),
        .ld_i   (m_ld),
        .ctrl_i (m_ctrl_d),
        .data_i (m_data_d),
        .ctrl_o (m_ctrl),
        .data_o (m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .clr_i  (clr),
                .ld_i   (s_ld),
                .ctrl_i (in_ctrl),
                .data_i (in_data),
                .ctrl_o (s_ctrl),
                .data_o (s_data)
            );
        end else begin : g_no_skid
            assign s_ctrl = '0;
            assign s_data = '0;
        end
    endgenerate

    // A bubble must never carry write enables downstream.
    assign out_ctrl  = out_valid ? m_ctrl : CTRL_NOP[CTRL_W-1:0];
    assign out_data  = m_data;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance checked against FIFO-queue reference models.
module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [CW+DW-1:0] qa[$];
    logic [CW+DW-1:0] qb[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_ctrl   (a_in_ctrl),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ctrl  (a_out_ctrl),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ctrl   (b_in_ctrl),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for SKID=1: a FIFO of at most two beats; ready whenever there is room.
    always @(negedge clk) begin
        logic exp_rdy;
        if (mon_en) begin
            exp_rdy = !reset && !a_flush && (qa.size() < 2);
            chk("a_in_ready", {63'd0, a_in_ready}, {63'd0, exp_rdy});
            chk("a_occupancy", {62'd0, a_occ}, 64'(qa.size()));
            chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, qa.size() != 0});
            if (reset) chk("a_reset_data", {32'd0, a_out_data}, 64'd0);
            if (qa.size() != 0) begin
                chk("a_out_data", {32'd0, a_out_data}, {32'd0, qa[0][DW-1:0]});
                chk("a_out_ctrl", {58'd0, a_out_ctrl}, {58'd0, qa[0][CW+DW-1:DW]});
            end else begin
                chk("a_bubble_ctrl", {58'd0, a_out_ctrl}, 64'd0);
            end
            if (reset || a_flush) begin
                qa.delete();
            end else begin
                if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
                if (a_in_valid && exp_rdy) qa.push_back({a_in_ctrl, a_in_data});
            end
        end
    end

    // Reference for SKID=0: a single-entry FIFO that may refill in the same cycle it drains.
    always @(negedge clk) begin
        logic exp_rdy;
        if (mon_en) begin
            exp_rdy = !reset && !b_flush && (qb.size() == 0 || b_out_ready);
            chk("b_in_ready", {63'd0, b_in_ready}, {63'd0, exp_rdy});
            chk("b_occupancy", {62'd0, b_occ}, 64'(qb.size()));
            chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, qb.size() != 0});
            if (reset) chk("b_reset_data", {32'd0, b_out_data}, 64'd0);
            if (qb.size() != 0) begin
                chk("b_out_data", {32'd0, b_out_data}, {32'd0, qb[0][DW-1:0]});
                chk("b_out_ctrl", {58'd0, b_out_ctrl}, {58'd0, qb[0][CW+DW-1:DW]});
            end else begin
                chk("b_bubble_ctrl", {58'd0, b_out_ctrl}, 64'd0);
            end
            if (reset || b_flush) begin
                qb.delete();
            end else begin
                if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
                if (b_in_valid && exp_rdy) qb.push_back({b_in_ctrl, b_in_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        a_in_valid = v;
        a_in_ctrl  = c;
        a_in_data  = d;
        step();
    endtask

    initial begin
        logic [2:0] tog [6];
        tog = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd1};

        a_flush = 0; a_in_valid = 1; a_out_ready = 0; a_in_ctrl = 6'h15; a_in_data = 32'h99;
        b_flush = 0; b_in_valid = 1; b_out_ready = 0; b_in_ctrl = 6'h2A; b_in_data = 32'h77;

        // Reset held two cycles with valid input offered.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        a_in_valid = 0;
        b_in_valid = 0;
        step();

        // Streaming 1,2,3 with downstream always ready.
        a_out_ready = 1;
        for (int i = 1; i <= 3; i++) send_a(1'b1, 6'($urandom), 32'(i));
        send_a(1'b0, '0, '0);
        step();

        // Stall: 0xA then 0xB fill both slots, then drain in order.
        a_out_ready = 0;
        send_a(1'b1, 6'h01, 32'hA);
        send_a(1'b1, 6'h02, 32'hB);
        send_a(1'b1, 6'h03, 32'hD);
        a_in_valid = 0;
        step();
        a_out_ready = 1;
        step();
        step();
        step();

        // Flush while in TWO with a beat on the input.
        a_out_ready = 0;
        send_a(1'b1, 6'h11, 32'h1);
        send_a(1'b1, 6'h12, 32'h2);
        a_flush = 1;
        send_a(1'b1, 6'h13, 32'hC);
        a_flush = 0;
        send_a(1'b0, '0, '0);
        a_out_ready = 1;
        step();

        // Bubble after an all-ones control beat.
        send_a(1'b1, 6'h3F, 32'h55);
        send_a(1'b0, '0, '0);
        step();

        // SKID=0: continuous valid while out_ready toggles.
        b_in_valid = 1;
        foreach (tog[i]) begin
            b_out_ready = tog[i][0];
            b_in_ctrl   = 6'($urandom);
            b_in_data   = $urandom;
            step();
        end
        b_in_valid = 0;
        b_out_ready = 1;
        step();

        // Randomised traffic on both instances, with occasional flush.
        for (int n = 0; n < 400; n++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 9) < 6);
            a_flush     = ($urandom_range(0, 29) == 0);
            a_in_ctrl   = 6'($urandom);
            a_in_data   = $urandom;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 9) < 6);
            b_flush     = ($urandom_range(0, 29) == 0);
            b_in_ctrl   = 6'($urandom);
            b_in_data   = $urandom;
            step();
        end

        // Drain both and confirm nothing remains.
        a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_flush = 0; b_out_ready = 1;
        for (int n = 0; n < 4; n++) step();
        chk("a_drained", 64'(qa.size()), 64'd0);
        chk("b_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
